// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : 32-bit sequential radix-2 non-restoring divider.
// Build option: define DIV_SIGNED_EN for two's-complement signed division.
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_divider (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iStart,
  input  logic [31:0] iDividend,
  input  logic [31:0] iDivisor,
  output logic [31:0] oQuotient,
  output logic [31:0] oRemainder,
  output logic        oBusy,
  output logic        oDone,
  output logic        oDivZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  count;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        zero_pend;

  logic [32:0] shifted;
  logic [32:0] step;
  logic [31:0] fixed_rem;
  logic [31:0] mag_dividend;
  logic [31:0] mag_divisor;
  logic [31:0] res_q;
  logic [31:0] res_r;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  // The final remainder always lies in [0, dvs), so 32 bits suffice for the fix-up.
  always_comb begin
    shifted   = {rem[31:0], quo[31]};
    step      = rem[32] ? (shifted + {1'b0, dvs}) : (shifted - {1'b0, dvs});
    fixed_rem = rem[31:0] + (rem[32] ? dvs : 32'd0);
`ifdef DIV_SIGNED_EN
    mag_dividend = iDividend[31] ? (~iDividend + 32'd1) : iDividend;
    mag_divisor  = iDivisor[31]  ? (~iDivisor + 32'd1)  : iDivisor;
    res_q        = neg_q ? (~quo + 32'd1) : quo;
    res_r        = neg_r ? (~fixed_rem + 32'd1) : fixed_rem;
`else
    mag_dividend = iDividend;
    mag_divisor  = iDivisor;
    res_q        = quo;
    res_r        = fixed_rem;
`endif
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      count      <= 6'd0;
      rem        <= 33'd0;
      quo        <= 32'd0;
      dvs        <= 32'd0;
      zero_pend  <= 1'b0;
      oQuotient  <= 32'd0;
      oRemainder <= 32'd0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oDivZero   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            oBusy    <= 1'b1;
            oDivZero <= 1'b0;
            count    <= 6'd0;
            rem      <= 33'd0;
            dvs      <= mag_divisor;
`ifdef DIV_SIGNED_EN
            neg_q    <= iDividend[31] ^ iDivisor[31];
            neg_r    <= iDividend[31];
`endif
            if (iDivisor == 32'd0) begin
              // Raw dividend is kept so it can be returned as the remainder.
              quo       <= iDividend;
              zero_pend <= 1'b1;
              state     <= DONE;
            end else begin
              quo       <= mag_dividend;
              state     <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= step;
          quo   <= {quo[30:0], ~step[32]};
          count <= count + 6'd1;
          if (count == 6'd31) begin
            count <= 6'd0;
            state <= FIX;
          end
        end
        FIX: begin
          oQuotient  <= res_q;
          oRemainder <= res_r;
          oDone      <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          // A zero divisor spends one extra cycle here before publishing results.
          if (zero_pend) begin
            zero_pend  <= 1'b0;
            oQuotient  <= 32'hFFFF_FFFF;
            oRemainder <= quo;
            oDivZero   <= 1'b1;
            oDone      <= 1'b1;
          end else begin
            oBusy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// tb_seq_divider : scoreboard-based self-checking bench for seq_divider.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;

  logic        iClk;
  logic        nRst;
  logic        iStart;
  logic [31:0] iDividend;
  logic [31:0] iDivisor;
  logic [31:0] oQuotient;
  logic [31:0] oRemainder;
  logic        oBusy;
  logic        oDone;
  logic        oDivZero;

  seq_divider dut (
    .iClk       (iClk),
    .nRst       (nRst),
    .iStart     (iStart),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oDivZero   (oDivZero)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   done_count = 0;
  exp_t last_exp;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.dz  = 1'b0;
    e.due = 0;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end
`ifdef DIV_SIGNED_EN
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end
`else
    else begin
      e.q = a / b;
      e.r = a % b;
    end
`endif
    return e;
  endfunction

  // Called at a falling edge; the next rising edge is the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    iStart    = 1'b1;
    iDividend = a;
    iDivisor  = b;
    e         = model(a, b);
    e.due     = cyc + ((b == 32'd0) ? 2 : 34);
    sb.push_back(e);
    last_exp  = e;
    @(negedge iClk);
    check("busy_after_start", {31'd0, oBusy}, 32'd1);
    iStart    = 1'b0;
    iDividend = $urandom;
    iDivisor  = $urandom;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge iClk);
      if (oDone === 1'b1) seen = 1'b1;
    end
    check("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  always @(posedge iClk) begin
    exp_t e;
    #1;
    if (oDone === 1'b1) begin
      done_count++;
      check("pending_on_done", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("quotient", oQuotient, e.q);
        check("remainder", oRemainder, e.r);
        check("div_zero", {31'd0, oDivZero}, {31'd0, e.dz});
        check("done_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] dir_a [8] = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'd7,
                             32'h8000_0001, 32'hFFFF_FFFF, 32'h1234_5678, 32'd1};
  logic [31:0] dir_b [8] = '{32'd1, 32'd7, 32'd3, 32'hFFFF_FFFF,
                             32'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE};

  initial begin
    int dc;
    nRst      = 1'b0;
    iStart    = 1'b0;
    iDividend = 32'd0;
    iDivisor  = 32'd0;
    repeat (3) @(negedge iClk);
    check("rst_quotient", oQuotient, 32'd0);
    check("rst_remainder", oRemainder, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_done", {31'd0, oDone}, 32'd0);
    check("rst_div_zero", {31'd0, oDivZero}, 32'd0);

    // Start on the very first edge after reset release.
    nRst = 1'b1;
    start_op(32'd100, 32'd7);
    wait_done();
    check("q_100_7", oQuotient, 32'd14);
    check("r_100_7", oRemainder, 32'd2);
    @(negedge iClk);
    check("busy_clear", {31'd0, oBusy}, 32'd0);
    check("hold_q", oQuotient, last_exp.q);

    start_op(32'hFFFF_FF9C, 32'd7);
    wait_done();
`ifdef DIV_SIGNED_EN
    check("q_neg100_7", oQuotient, 32'hFFFF_FFF2);
    check("r_neg100_7", oRemainder, 32'hFFFF_FFFE);
`else
    check("q_big_7", oQuotient, 32'h2492_4916);
    check("r_big_7", oRemainder, 32'h0000_0002);
`endif
    @(negedge iClk);

    start_op(32'd1234, 32'd0);
    wait_done();
    check("dz_flag", {31'd0, oDivZero}, 32'd1);
    @(negedge iClk);
    check("dz_hold", {31'd0, oDivZero}, 32'd1);

    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    @(negedge iClk);

    // Start pulse while busy must be ignored.
    start_op(32'd50, 32'd5);
    repeat (8) @(negedge iClk);
    iStart    = 1'b1;
    iDividend = 32'd9;
    iDivisor  = 32'd3;
    @(negedge iClk);
    iStart    = 1'b0;
    wait_done();
    // Start in DONE is ignored; start in the following IDLE cycle is taken.
    iStart    = 1'b1;
    iDividend = 32'd77;
    iDivisor  = 32'd0;
    @(negedge iClk);
    start_op(32'd1000, 32'd33);
    wait_done();
    @(negedge iClk);

    for (int i = 0; i < 8; i++) begin
      start_op(dir_a[i], dir_b[i]);
      wait_done();
      @(negedge iClk);
    end
    for (int i = 0; i < 4; i++) begin
      start_op($urandom, $urandom_range(1, 32'h0001_0000));
      wait_done();
      @(negedge iClk);
    end

    // Reset mid-operation abandons the division.
    start_op(32'd50, 32'd5);
    repeat (13) @(negedge iClk);
    #2;
    nRst = 1'b0;
    #1;
    check("mid_rst_quotient", oQuotient, 32'd0);
    check("mid_rst_remainder", oRemainder, 32'd0);
    check("mid_rst_busy", {31'd0, oBusy}, 32'd0);
    check("mid_rst_done", {31'd0, oDone}, 32'd0);
    check("mid_rst_div_zero", {31'd0, oDivZero}, 32'd0);
    sb.delete();
    dc = done_count;
    repeat (40) @(negedge iClk);
    check("no_done_after_rst", done_count, dc);
    nRst = 1'b1;
    start_op(32'd9, 32'd4);
    wait_done();
    check("q_9_4", oQuotient, 32'd2);
    check("r_9_4", oRemainder, 32'd1);
    repeat (3) @(negedge iClk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 iClk  input  1  single clock; all state updates on rising edge.
REQ-002 nRst  input  1  asynchronous, active-low reset.
REQ-003 iStart  input  1  start request; sampled only in IDLE.
REQ-004 iDividend  input  32  dividend, captured on accepted start.
REQ-005 iDivisor  input  32  divisor, captured on accepted start.
REQ-006 oQuotient  output  32  quotient; valid from oDone until next accepted start.
REQ-007 oRemainder  output  32  remainder; same validity as oQuotient.
REQ-008 oBusy  output  1  high from the cycle after an accepted start through the oDone cycle.
REQ-009 oDone  output  1  single-cycle completion pulse.
REQ-010 oDivZero  output  1  divisor was zero; valid with oDone, held with results.

Function
REQ-011 FSM states SHALL be IDLE, CALC, FIX and DONE; encoding is free.
REQ-012 IDLE: iStart=1 at an edge SHALL capture the operands, clear oDivZero and go to CALC, or go to DONE when iDivisor==0.
REQ-013 CALC SHALL run radix-2 non-restoring iterations on operand magnitudes, one quotient bit per cycle, MSB first, with a 6-bit counter running 0..31.
REQ-014 The 32nd CALC cycle SHALL go to FIX; FIX SHALL do the remainder correction (add divisor back if partial remainder is negative) and apply result signs, then go to DONE.
REQ-015 DONE SHALL assert oDone for exactly one cycle, write results to the output registers, and return to IDLE.
REQ-016 Latency: oDone SHALL be high in the 34th cycle after the edge that accepted iStart, for every non-zero divisor.
REQ-017 Divide by zero: oDone SHALL be high in the 2nd cycle after the accepting edge, with oDivZero=1, oQuotient=32'hFFFFFFFF and oRemainder=captured dividend.
REQ-018 Signed semantics: the quotient SHALL truncate toward zero; the remainder sign SHALL follow the dividend; dividend == quotient*divisor + remainder (mod 2^32).
REQ-019 Overflow: 32'h80000000 / 32'hFFFFFFFF SHALL give quotient 32'h80000000 and remainder 0, with no flag.
REQ-020 iStart while oBusy=1 SHALL be ignored; the operation in flight SHALL be unaffected.
REQ-021 iStart high in the DONE cycle SHALL be ignored; iStart in the following IDLE cycle SHALL be accepted (back-to-back throughput is one operation per 35 cycles).
REQ-022 Operand inputs SHALL be don't-care except at the accepting edge.
REQ-023 The internal datapath SHALL use a 33-bit partial remainder; no result bit SHALL depend on uncaptured inputs.

Reset
REQ-024 nRst low SHALL immediately force IDLE, counter=0, oQuotient=0, oRemainder=0, oBusy=0, oDone=0 and oDivZero=0, regardless of iClk.
REQ-025 Reset mid-operation SHALL abandon the division; no oDone SHALL follow.
REQ-026 The first iStart SHALL be accepted on the first rising edge after nRst deasserts.

Configuration
REQ-027 Macro DIV_SIGNED_EN defined: two's-complement signed division per REQ-018/REQ-019.
REQ-028 DIV_SIGNED_EN undefined: unsigned division; FIX SHALL only do the remainder correction; REQ-019 does not apply.
REQ-029 Latency and the divide-by-zero behaviour SHALL be identical in both builds.

Verification
REQ-030 Start 100 / 7 -> oDone at cycle 34; quotient 14, remainder 2, oDivZero=0.
REQ-031 (signed) Start -100 / 7 -> quotient 32'hFFFFFFF2, remainder 32'hFFFFFFFE; (unsigned) 32'hFFFFFF9C / 7 -> quotient 32'h24924916, remainder 32'h00000002.
REQ-032 Start 1234 / 0 -> oDone at cycle 2; oDivZero=1, quotient 32'hFFFFFFFF, remainder 1234.
REQ-033 (signed) Start 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0.
REQ-034 Start 50 / 5, pulse iStart with 9 / 3 at cycle 10 -> single oDone at cycle 34 with quotient 10, remainder 0.
REQ-035 Start 50 / 5, drop nRst at cycle 15 -> all outputs 0 at once, no oDone; then start 9 / 4 -> quotient 2, remainder 1 at cycle 34.
